// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM state encoding,
// line levels and the default bit timing.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level valid/ready handshake into the UART transmitter.
// The master offers bytes and the slave (uart_tx) accepts them.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: bit_tick pulses on the last clock of every CLKS_PER_BIT period
// while enabled. bit_pre_tick pulses one clock earlier, so a registered output can line up with bit_tick.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick,
    output logic bit_pre_tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] clk_cnt;

    assign bit_tick     = enable && (clk_cnt == LAST_CNT);
    assign bit_pre_tick = enable && (clk_cnt == PRE_CNT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt <= '0;
        end else if (clear) begin
            clk_cnt <= '0;
        end else if (enable) begin
            clk_cnt <= bit_tick ? '0 : clk_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      data_line,
    output logic      flag
);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    uart_state_t          state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tx_ready_q;
    logic                 accept;
    logic                 bit_tick;
    logic                 bit_pre_tick;

    assign accept       = bus.tx_valid && tx_ready_q;
    assign bus.tx_ready = tx_ready_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk          (clk),
        .rst          (rst),
        .clear        (accept),
        .enable       (state != IDLE),
        .bit_tick     (bit_tick),
        .bit_pre_tick (bit_pre_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^bus.tx_data;
        end
    end
`endif

    // data_line follows the state one edge later, so every line bit lags its state by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tx_ready_q <= 1'b1;
            data_line  <= LINE_IDLE;
            flag       <= 1'b0;
        end else begin
            flag <= 1'b0;
            case (state)
                IDLE: begin
                    data_line <= LINE_IDLE;
                    if (accept) begin
                        shift_reg  <= bus.tx_data;
                        bit_cnt    <= '0;
                        tx_ready_q <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    data_line <= LINE_START;
                    if (bit_tick) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    data_line <= shift_reg[0];
                    if (bit_tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    data_line <= parity_bit;
                    if (bit_tick) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    data_line <= LINE_IDLE;
                    // Raised one clock early so the pulse covers the final clock of the last stop bit.
                    if (bit_pre_tick && (bit_cnt == LAST_STOP)) begin
                        flag <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt    <= '0;
                            tx_ready_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    data_line  <= LINE_IDLE;
                    tx_ready_q <= 1'b1;
                    bit_cnt    <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: cycle-exact frame model plus a line receiver fed by a byte scoreboard.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 8;
    localparam int DB  = 8;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int FRAME = (1 + DB + PB + SB) * CPB;

    logic clk = 1'b0;
    logic rst;
    logic data_line;
    logic flag;

    uart_tx_if #(.DATA_BITS(DB)) bus ();

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .data_line (data_line),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int flag_cnt = 0;
    int rx_cnt = 0;
    logic [DB-1:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst && flag === 1'b1) flag_cnt++;
    end

    // Line receiver: samples mid-bit, pops the expected byte and compares.
    bit            rx_busy = 1'b0;
    int            rx_pos;
    int            rx_b;
    logic [DB-1:0] rx_byte;
    logic [DB-1:0] rx_exp;
    logic          rx_par;

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (data_line === LINE_START) begin
                rx_busy = 1'b1;
                rx_pos  = 0;
            end
        end else begin
            rx_pos++;
            if (rx_pos % CPB == CPB / 2) begin
                rx_b = rx_pos / CPB;
                if (rx_b >= 1 && rx_b <= DB) begin
                    rx_byte[rx_b-1] = data_line;
                end else if (PB == 1 && rx_b == DB + 1) begin
                    rx_par = data_line;
                end else if (rx_b == DB + PB + 1) begin
                    rx_busy = 1'b0;
                    rx_cnt++;
                    n_vec++;
                    if (data_line !== LINE_IDLE) begin
                        n_err++;
                        $display("FAIL rx_stop: got %b want 1", data_line);
                    end
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rx_unexpected: got byte %h want no frame", rx_byte);
                    end else begin
                        rx_exp = exp_q.pop_front();
                        if (rx_byte !== rx_exp) begin
                            n_err++;
                            $display("FAIL rx_byte: got %h want %h", rx_byte, rx_exp);
                        end
                        if (PB == 1) begin
                            n_vec++;
                            if (rx_par !== ^rx_exp) begin
                                n_err++;
                                $display("FAIL rx_parity: got %b want %b", rx_par, ^rx_exp);
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic logic model_line(input logic [DB-1:0] d, input int k);
        int idx;
        if (k == 0) return 1'b1;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
        if (PB == 1 && idx == DB + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (bus.tx_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        n_vec++;
        n_err++;
        $display("FAIL %s_ready_timeout: got tx_ready=%b want 1", name, bus.tx_ready);
    endtask

    task automatic check_bit(input string name, input int k, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s k=%0d: got %b want %b", name, k, got, want);
        end
    endtask

    task automatic send_and_check(input logic [DB-1:0] d, input string name);
        bit ok;
        int rx_before;
        wait_ready(name, ok);
        if (!ok) return;
        rx_before   = rx_cnt;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        exp_q.push_back(d);
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 0) bus.tx_valid = 1'b0;
            check_bit({name, "_line"}, k, data_line, model_line(d, k));
            check_bit({name, "_flag"}, k, flag, k == FRAME - 1);
            check_bit({name, "_ready"}, k, bus.tx_ready, k >= FRAME);
        end
        n_vec++;
        if (rx_cnt !== rx_before + 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_rx_count: got %0d frames want %0d", name, rx_cnt - rx_before, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_bit("reset_line", k, data_line, 1'b1);
            check_bit("reset_ready", k, bus.tx_ready, 1'b1);
            check_bit("reset_flag", k, flag, 1'b0);
        end
    endtask

    task automatic test_single_frame();
        send_and_check(8'hA5, "a5");
    endtask

    task automatic test_back_to_back();
        bit ok;
        int k_ready = -1;
        int rx_before = rx_cnt;
        int flag_before = flag_cnt;
        wait_ready("b2b", ok);
        if (!ok) return;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        @(negedge clk);
        bus.tx_data = 8'hC3;
        for (int k = 1; k <= FRAME + 2; k++) begin
            @(negedge clk);
            if (k_ready < 0 && bus.tx_ready === 1'b1) k_ready = k;
            if (k == FRAME + 1) begin
                bus.tx_valid = 1'b0;
                check_bit("b2b_idle_line", k, data_line, 1'b1);
                check_bit("b2b_second_accept", k, bus.tx_ready, 1'b0);
            end
            if (k == FRAME + 2) check_bit("b2b_second_start", k, data_line, 1'b0);
        end
        n_vec++;
        if (k_ready != FRAME) begin
            n_err++;
            $display("FAIL b2b_ready_cycle: got %0d want %0d", k_ready, FRAME);
        end
        wait_ready("b2b_end", ok);
        repeat (2) @(negedge clk);
        n_vec++;
        if (rx_cnt != rx_before + 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_rx_count: got %0d want 2", rx_cnt - rx_before);
        end
        n_vec++;
        if (flag_cnt != flag_before + 2) begin
            n_err++;
            $display("FAIL b2b_flags: got %0d want 2", flag_cnt - flag_before);
        end
    endtask

    task automatic test_input_stability();
        bit ok;
        int rx_before = rx_cnt;
        int flag_before = flag_cnt;
        wait_ready("stab", ok);
        if (!ok) return;
        bus.tx_data  = 8'h12;
        bus.tx_valid = 1'b1;
        exp_q.push_back(8'h12);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (19) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_ready("stab_end", ok);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_bit("stab_idle_line", k, data_line, 1'b1);
            check_bit("stab_idle_ready", k, bus.tx_ready, 1'b1);
        end
        n_vec++;
        if (rx_cnt != rx_before + 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stab_rx_count: got %0d want 1", rx_cnt - rx_before);
        end
        n_vec++;
        if (flag_cnt != flag_before + 1) begin
            n_err++;
            $display("FAIL stab_flags: got %0d want 1", flag_cnt - flag_before);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int flag_before = flag_cnt;
        wait_ready("rstmid", ok);
        if (!ok) return;
        bus.tx_data  = 8'h33;
        bus.tx_valid = 1'b1;
        exp_q.push_back(8'h33);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        check_bit("rstmid_before", 30, data_line, model_line(8'h33, 30));
        #2 rst = 1'b1;
        #1;
        check_bit("rstmid_async_line", 30, data_line, 1'b1);
        check_bit("rstmid_async_ready", 30, bus.tx_ready, 1'b1);
        check_bit("rstmid_async_flag", 30, flag, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (flag_cnt != flag_before) begin
            n_err++;
            $display("FAIL rstmid_no_flag: got %0d flags want 0", flag_cnt - flag_before);
        end
        send_and_check(8'h55, "after_rst");
    endtask

    task automatic test_parity();
        send_and_check(8'h07, "par07");
        send_and_check(8'h03, "par03");
    endtask

    initial begin
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_input_stability();
        test_reset_mid_frame();
        if (PB == 1) test_parity();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before 1 ms");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the counterpart to uart_rx on the same serial data_line.
- Accepts a byte over a valid/ready handshake.
- Serialises it LSB-first as start bit, DATA_BITS data bits, optional parity bit, then STOP_BITS stop bits.
- Each bit is held CLKS_PER_BIT clocks.
- Used for FPGA-to-host links and as the loopback driver for uart_rx benches.

Parameters:
- CLKS_PER_BIT, 8: clocks per serial bit (matches uart_rx default timing); legal range >=2.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- tx_valid, input, 1: byte on tx_data is offered for transmission.
- tx_data, input, DATA_BITS: byte to send; sampled only on accept.
- tx_ready, output, 1: transmitter idle and able to accept.
- data_line, output, 1: serial line; idles high.
- flag, output, 1: one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (asynchronous, immediate):
  - data_line=1, tx_ready=1, flag=0.
  - State=IDLE; bit counter and clock counter = 0; shift register = 0.
- Accept: on the rising edge where tx_valid && tx_ready.
  - tx_data is captured into the shift register.
  - State goes to START.
  - tx_ready drops in the same edge.
- Registered output: data_line changes on the edge after the state change. After accept at edge N, data_line=0 from edge N+1.
- States and transitions (each state holds for CLKS_PER_BIT clocks, counted 0..CLKS_PER_BIT-1):
  - IDLE: data_line=1; tx_ready=1.
  - START: data_line=0.
  - DATA: data_line = shift register bit0; shift right at the end of each bit; bit counter counts 0..DATA_BITS-1, then moves to PARITY (if compiled in) or STOP.
  - PARITY: see Optional Feature.
  - STOP: data_line=1 for STOP_BITS*CLKS_PER_BIT clocks. flag=1 on the final clock. Next edge goes to IDLE.
- Frame length, accept edge to return to IDLE: (1 + DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT clocks, where P=1 with parity and 0 without. Default: 80 clocks.
- Back-to-back frames:
  - tx_ready is high in IDLE only, so the minimum gap between frames is one idle clock (data_line=1).
  - A tx_valid held high is accepted on the first IDLE cycle.
- Input stability:
  - tx_data or tx_valid changing mid-frame has no effect.
  - tx_valid while tx_ready=0 is ignored; it is not queued.
- Reset mid-frame: the line returns high immediately, the frame is truncated, no flag is generated, and the transmitter is ready after reset deasserts.
- Counters are sized with $clog2 of their maximum value; no wrap-around occurs outside defined terminal counts.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - The PARITY state is inserted after DATA for CLKS_PER_BIT clocks.
  - data_line = even parity, i.e. XOR of the captured data bits, computed at accept and stored in a register.
- When undefined:
  - No PARITY state and no parity register.
  - DATA goes directly to STOP; frame length omits one bit.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP.
  - LINE_IDLE=1'b1 and LINE_START=1'b0.
  - Default CLKS_PER_BIT constant, shared with uart_rx.
- Sub-module uart_baud_gen (natural split):
  - Clock counter producing a one-cycle bit_tick every CLKS_PER_BIT clocks.
  - Inputs: clear on accept/state change, and enable; the FSM advances on bit_tick.

Test Plan:
- Reset then idle 20 clocks -> data_line=1, tx_ready=1, flag=0 throughout.
- Send 0xA5 (no parity) -> data_line, 8 clocks per bit: 0, then 1,0,1,0,0,1,0,1, then 1. flag pulses on clock 80 after accept; tx_ready returns 1 on the next edge.
- Loopback into uart_rx: send 0x3C then 0xC3 with tx_valid held high -> uart_rx data_byte 0x3C then 0xC3, two receiver flags, exactly one idle clock between frames.
- Change tx_data to 0xFF and pulse tx_valid during frame of 0x12 -> frame stays 0x12; second request ignored; one flag.
- Assert rst at clock 30 of a frame -> data_line=1 asynchronously within the same cycle; no flag; a new 0x55 after release transmits correctly.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit=1 after bit7; frame 88 clocks. Send 0x03 -> parity bit=0.
